// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The requester side uses the master modport, the unit uses the slave modport.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] Result;
   logic            V;
   logic            N;
   logic            Zero;

   modport master (
      output in_valid, op, A, B, out_ready,
      input  in_ready, out_valid, Result, V, N, Zero
   );

   modport slave (
      input  in_valid, op, A, B, out_ready,
      output in_ready, out_valid, Result, V, N, Zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, XLEN-parametrised.
// Shift-add multiply and restoring divide, one step per clock, operands handled
// as magnitudes with a sign fix-up on the final step. Divide-by-zero and signed
// overflow are resolved at accept time and go straight to DONE.
// Optional feature: define MULDIV_FLAGS_EN to register the V/N/Zero flags with
// Result; otherwise those outputs are tied low.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// CALC  | one multiply or divide step per clock, counter counts down
// DONE  | Result valid (out_valid=1), held until out_ready
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;
   logic              res_neg;
   logic [XLEN-1:0]   result_q;

   logic              a_neg, b_neg, a_signed, b_signed;
   logic              div_zero, div_ovf, is_special, neg_in;
   logic [XLEN-1:0]   a_mag, b_mag, special_res;

   logic [XLEN:0]     mul_sum, div_diff;
   logic [2*XLEN-1:0] acc_nxt, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

   logic              accept, last_step, res_load;
   logic [XLEN-1:0]   res_val;

   // Decode the incoming request: signedness, magnitudes, result sign, special divides
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (bus.op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      a_neg = a_signed & bus.A[XLEN-1];
      b_neg = b_signed & bus.B[XLEN-1];
      a_mag = a_neg ? -bus.A : bus.A;
      b_mag = b_neg ? -bus.B : bus.B;

      div_zero   = bus.op[2] && (bus.B == '0);
      div_ovf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                   (bus.A == MIN_NEG) && (bus.B == '1);
      is_special = div_zero | div_ovf;
      // op[1] selects remainder among the divide ops
      if (div_zero) special_res = bus.op[1] ? bus.A : '1;
      else          special_res = bus.op[1] ? '0 : bus.A;

      case (bus.op)
         OP_MULH, OP_DIV:   neg_in = a_neg ^ b_neg;
         OP_MULHSU, OP_REM: neg_in = a_neg;
         default:           neg_in = 1'b0;
      endcase
   end

   // One iteration step plus the sign fix-up and result select used on the last step
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
      if (op_q[2]) begin
         if (div_diff[XLEN]) acc_nxt = {acc[2*XLEN-2:0], 1'b0};
         else                acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_nxt = {mul_sum, acc[XLEN-1:1]};
      end
      prod_fix = res_neg ? -acc_nxt : acc_nxt;
      quo_fix  = res_neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      rem_fix  = res_neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:           calc_res = acc_nxt[XLEN-1:0];
         OP_DIV, OP_DIVU:  calc_res = quo_fix;
         OP_REM, OP_REMU:  calc_res = rem_fix;
         default:          calc_res = prod_fix[2*XLEN-1:XLEN];
      endcase
   end

   // Result capture points: special divide at accept, or the final CALC step
   always_comb begin
      accept    = (state == S_IDLE) && bus.in_valid;
      last_step = (state == S_CALC) && (cnt == CNT_W'(1));
      res_load  = (accept && is_special) || last_step;
      res_val   = (state == S_IDLE) ? special_res : calc_res;
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         opnd    <= '0;
         acc     <= '0;
         res_neg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  op_q    <= bus.op;
                  res_neg <= neg_in;
                  cnt     <= CNT_W'(XLEN);
                  if (is_special) begin
                     state <= S_DONE;
                  end else begin
                     // multiply: opnd=multiplicand, acc low=multiplier
                     // divide:   opnd=divisor,      acc low=dividend
                     opnd  <= bus.op[2] ? b_mag : a_mag;
                     acc   <= {{XLEN{1'b0}}, (bus.op[2] ? a_mag : b_mag)};
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc <= acc_nxt;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Result register, held from DONE until the next capture
   always_ff @(posedge clk) begin
      if (reset)         result_q <= '0;
      else if (res_load) result_q <= res_val;
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.Result    = result_q;

`ifdef MULDIV_FLAGS_EN
   logic v_q, n_q, zero_q;
   logic res_exc;

   // Only special divides raise V, and they are the only results captured in IDLE
   assign res_exc = (state == S_IDLE);

   // Flags registered alongside Result
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q    <= 1'b0;
         n_q    <= 1'b0;
         zero_q <= 1'b1;
      end else if (res_load) begin
         v_q    <= res_exc;
         n_q    <= res_val[XLEN-1];
         zero_q <= (res_val == '0);
      end
   end

   assign bus.V    = v_q;
   assign bus.N    = n_q;
   assign bus.Zero = zero_q;
`else
   assign bus.V    = 1'b0;
   assign bus.N    = 1'b0;
   assign bus.Zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus randomized ops against a
// 64-bit arithmetic reference model.
module tb_muldiv_unit;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   muldiv_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: RV32M semantics computed with plain 64-bit arithmetic
   function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic v, output logic special);
      logic [63:0] p;
      longint sa, sb, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      v = 1'b0;
      special = 1'b0;
      p = 64'd0;
      r = 32'd0;
      case (op)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
         default: begin
            if (b == 32'd0) begin
               special = 1'b1; v = 1'b1;
               r = op[1] ? a : 32'hFFFF_FFFF;
            end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               special = 1'b1; v = 1'b1;
               r = op[1] ? 32'd0 : a;
            end else begin
               case (op)
                  3'd4:    p = sa / sb;
                  3'd5:    p = ua / ub;
                  3'd6:    p = sa % sb;
                  default: p = ua % ub;
               endcase
               r = p[31:0];
            end
         end
      endcase
   endfunction

   task automatic check_flags(input string tag, input logic [31:0] r, input logic v);
`ifdef MULDIV_FLAGS_EN
      check_eq({tag, "_V"}, 64'(bus.V), 64'(v));
      check_eq({tag, "_N"}, 64'(bus.N), 64'(r[31]));
      check_eq({tag, "_Z"}, 64'(bus.Zero), 64'(r == 32'd0));
`else
      check_eq({tag, "_flags"}, 64'({bus.V, bus.N, bus.Zero}), 64'(0));
`endif
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp_r, held;
      logic        exp_v, exp_sp;
      int          cyc;
      bit          busy_bad, hold_bad;
      ref_model(op, a, b, exp_r, exp_v, exp_sp);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.A         = a;
      bus.B         = b;
      bus.out_ready = 1'b0;
      check_eq("in_ready_idle", 64'(bus.in_ready), 64'(1));
      @(posedge clk); #1;
      // operands changing after accept must not matter
      bus.in_valid = 1'b0;
      bus.op = 3'($urandom);
      bus.A  = $urandom;
      bus.B  = $urandom;
      cyc = 1;
      busy_bad = 1'b0;
      while (!bus.out_valid && cyc < 100) begin
         if (bus.in_ready) busy_bad = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      if (bus.in_ready) busy_bad = 1'b1;
      check_eq("latency", 64'(cyc), exp_sp ? 64'(1) : 64'(XLEN + 1));
      check_eq("busy_in_ready", 64'(busy_bad), 64'(0));
      check_eq("result", 64'(bus.Result), 64'(exp_r));
      check_flags("res", exp_r, exp_v);
      held = bus.Result;
      hold_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.op = 3'($urandom);
         bus.A  = $urandom;
         bus.B  = $urandom;
         @(posedge clk); #1;
         if (!bus.out_valid || bus.in_ready || bus.Result !== held) hold_bad = 1'b1;
      end
      if (hold > 0) check_eq("hold", 64'(hold_bad), 64'(0));
      // release with in_valid still high: must not be accepted on the same edge
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check_eq("release_out_valid", 64'(bus.out_valid), 64'(0));
      check_eq("release_in_ready", 64'(bus.in_ready), 64'(1));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
      check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
      check_eq({tag, "_result"}, 64'(bus.Result), 64'(0));
`ifdef MULDIV_FLAGS_EN
      check_eq({tag, "_flags"}, 64'({bus.V, bus.N, bus.Zero}), 64'(1));
`else
      check_eq({tag, "_flags"}, 64'({bus.V, bus.N, bus.Zero}), 64'(0));
`endif
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 3'd0;
      bus.A         = '0;
      bus.B         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      reset = 1'b0;

      // multiplies
      run_op(3'd0, 32'd124, 32'd73, 0);
      run_op(3'd1, -32'sd124, 32'd73, 0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
      // divides
      run_op(3'd4, -32'sd20, 32'd6, 0);
      run_op(3'd6, -32'sd20, 32'd6, 0);
      run_op(3'd5, 32'd124, 32'd73, 0);
      run_op(3'd7, 32'd124, 32'd73, 0);
      // special divides
      run_op(3'd4, 32'd5, 32'd0, 0);
      run_op(3'd6, 32'd5, 32'd0, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      // backpressure, then the next request must be accepted
      run_op(3'd0, 32'd1000, 32'd77, 10);
      run_op(3'd5, 32'd999, 32'd10, 0);

      // reset in the middle of CALC
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 3'd0;
      bus.A  = 32'd124;
      bus.B  = 32'd73;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_state("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      run_op(3'd0, 32'd3, -32'sd4, 0);

      // randomized ops
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
